// File: rtl/ula_sequencial_if.sv
// Execute-stage ALU bus: operation request from the control unit and registered result/status back.
interface ula_sequencial_if #(parameter int LARGURA = 8);
  logic               inicio;
  logic [LARGURA-1:0] entrada1;
  logic [LARGURA-1:0] entrada2;
  logic [2:0]         sinal_ula;
  logic [LARGURA-1:0] saida_ula;
  logic               valido;
  logic               ocupado;
  logic               zero;
  logic               carry;
  logic               overflow;
  logic               div_zero;

  modport master (
    output inicio, entrada1, entrada2, sinal_ula,
    input  saida_ula, valido, ocupado, zero, carry, overflow, div_zero
  );

  modport slave (
    input  inicio, entrada1, entrada2, sinal_ula,
    output saida_ula, valido, ocupado, zero, carry, overflow, div_zero
  );
endinterface

// File: rtl/ula_sequencial.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add MUL and restoring DIVU.
// state  | meaning
// OCIOSO | idle, accepts inicio; single-cycle ops complete here
// ITERA  | MUL/DIVU in flight, one bit per cycle, ocupado high
module ula_sequencial #(
  parameter int LARGURA = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  ula_sequencial_if.slave  bus
);

  localparam int W  = LARGURA;
  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] CNT_INI = CW'(LARGURA);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic {OCIOSO = 1'b0, ITERA = 1'b1} estado_t;

  estado_t         estado_q, estado_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    saida_q, saida_d;
  logic            valido_q, valido_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;

  logic [W:0]      soma, dif;
  logic [W-1:0]    res_sc;
  logic            c_sc, v_sc;
  logic [2*W-1:0]  prod_nxt;
  logic [W:0]      r_sh, r_sub;
  logic            cabe;
  logic [W-1:0]    r_nxt, quo_nxt;

  assign soma = {1'b0, bus.entrada1} + {1'b0, bus.entrada2};
  assign dif  = {1'b0, bus.entrada1} - {1'b0, bus.entrada2};

  always_comb begin
    res_sc = '0;
    c_sc   = 1'b0;
    v_sc   = 1'b0;
    case (bus.sinal_ula)
      OP_AND: res_sc = bus.entrada1 & bus.entrada2;
      OP_OR:  res_sc = bus.entrada1 | bus.entrada2;
      OP_ADD: begin
        res_sc = soma[W-1:0];
        c_sc   = soma[W];
        v_sc   = (bus.entrada1[W-1] == bus.entrada2[W-1]) && (soma[W-1] != bus.entrada1[W-1]);
      end
      OP_SUB: begin
        res_sc = dif[W-1:0];
        c_sc   = dif[W];
        v_sc   = (bus.entrada1[W-1] != bus.entrada2[W-1]) && (dif[W-1] != bus.entrada1[W-1]);
      end
      OP_SLT: res_sc = {{(W-1){1'b0}}, dif[W]};
      OP_NOR: res_sc = ~(bus.entrada1 | bus.entrada2);
      default: res_sc = '0;
    endcase
  end

  // MUL step: acc += multiplicand when the current multiplier LSB is set.
  assign prod_nxt = acc_q + (opb_q[0] ? opa_q : '0);

  // DIVU step: remainder lives in acc_q[W-1:0], dividend shifts out of opb_q as quotient shifts in.
  assign r_sh    = {acc_q[W-1:0], opb_q[W-1]};
  assign r_sub   = r_sh - {1'b0, opa_q[W-1:0]};
  assign cabe    = ~r_sub[W];
  assign r_nxt   = cabe ? r_sub[W-1:0] : r_sh[W-1:0];
  assign quo_nxt = {opb_q[W-2:0], cabe};

  always_comb begin
    estado_d = estado_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    saida_d  = saida_q;
    valido_d = 1'b0;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    case (estado_q)
      OCIOSO: begin
        if (bus.inicio) begin
          op_d = bus.sinal_ula;
          if (bus.sinal_ula == OP_MUL) begin
            acc_d    = '0;
            opa_d    = {{W{1'b0}}, bus.entrada1};
            opb_d    = bus.entrada2;
            cnt_d    = CNT_INI;
            estado_d = ITERA;
          end else if (bus.sinal_ula == OP_DIVU && bus.entrada2 != '0) begin
            acc_d    = '0;
            opa_d    = {{W{1'b0}}, bus.entrada2};
            opb_d    = bus.entrada1;
            cnt_d    = CNT_INI;
            estado_d = ITERA;
          end else if (bus.sinal_ula == OP_DIVU) begin
            saida_d  = '1;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            dz_d     = 1'b1;
            valido_d = 1'b1;
          end else begin
            saida_d  = res_sc;
            carry_d  = c_sc;
            ovf_d    = v_sc;
            dz_d     = 1'b0;
            valido_d = 1'b1;
          end
        end
      end
      ITERA: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = prod_nxt;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = {{W{1'b0}}, r_nxt};
          opb_d = quo_nxt;
        end
        if (cnt_q == CW'(1)) begin
          estado_d = OCIOSO;
          valido_d = 1'b1;
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
          if (op_q == OP_MUL) begin
            saida_d = prod_nxt[W-1:0];
            carry_d = |prod_nxt[2*W-1:W];
          end else begin
            saida_d = quo_nxt;
            carry_d = 1'b0;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase
    // saida only changes on completion, so zero tracks it without extra gating
    zero_d = (saida_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      saida_q  <= '0;
      valido_q <= 1'b0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      saida_q  <= saida_d;
      valido_q <= valido_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.saida_ula = saida_q;
  assign bus.valido    = valido_q;
  assign bus.ocupado   = (estado_q == ITERA);
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Randomised bench for ula_sequencial against an arithmetic reference model.
module tb_ula_sequencial;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  ula_sequencial_if #(.LARGURA(W)) u_if ();
  ula_sequencial #(.LARGURA(W)) dut (.clock(clk), .reset_n(rst_n), .bus(u_if.slave));

  always #5 clk = ~clk;

  function automatic void modelo(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic c, output logic v, output logic dz);
    int ia, ib, sa, sb, t;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    c = 1'b0; v = 1'b0; dz = 1'b0; t = 0;
    case (op)
      3'd0: t = ia & ib;
      3'd1: t = ia | ib;
      3'd2: begin t = ia + ib; c = (t > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      3'd3: begin t = ia - ib; c = (ia < ib); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      3'd4: t = (ia < ib) ? 1 : 0;
      3'd5: t = ~(ia | ib);
      3'd6: begin t = ia * ib; c = (t > 255); end
      default: begin
        if (ib == 0) begin t = 255; dz = 1'b1; end
        else t = ia / ib;
      end
    endcase
    r = t[7:0];
  endfunction

  function automatic int lat_esperada(input logic [2:0] op, input logic [7:0] b);
    return (op == 3'd6 || (op == 3'd7 && b != 8'd0)) ? W + 1 : 1;
  endfunction

  // Issues one op from a point just after a rising edge; optionally pokes inicio mid-operation.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int poke_at,
                        output logic [11:0] obs, output int lat, output bit busy_ok, output bit pulse_ok);
    u_if.inicio = 1'b1;
    u_if.sinal_ula = op;
    u_if.entrada1 = a;
    u_if.entrada2 = b;
    @(posedge clk); #1;
    u_if.inicio = 1'b0;
    u_if.sinal_ula = 3'($urandom);
    u_if.entrada1 = 8'($urandom);
    u_if.entrada2 = 8'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!u_if.valido && lat < 4 * W) begin
      if (!u_if.ocupado) busy_ok = 1'b0;
      if (lat == poke_at) u_if.inicio = 1'b1;
      @(posedge clk); #1;
      u_if.inicio = 1'b0;
      lat++;
    end
    if (u_if.ocupado) busy_ok = 1'b0;
    obs = {u_if.saida_ula, u_if.zero, u_if.carry, u_if.overflow, u_if.div_zero};
    @(posedge clk); #1;
    pulse_ok = !u_if.valido && !u_if.ocupado;
  endtask

  task automatic test_reset();
    u_if.inicio = 1'b0; u_if.sinal_ula = '0; u_if.entrada1 = '0; u_if.entrada2 = '0;
    #12;
    checks++;
    if ({u_if.saida_ula, u_if.valido, u_if.ocupado, u_if.zero, u_if.carry, u_if.overflow, u_if.div_zero}
        !== {8'h00, 6'b001000}) begin
      errors++;
      $display("FAIL reset_state got r=%h v%b o%b z%b c%b ov%b dz%b want r=00 v0 o0 z1 c0 ov0 dz0",
               u_if.saida_ula, u_if.valido, u_if.ocupado, u_if.zero, u_if.carry, u_if.overflow, u_if.div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Directed test-plan ops plus random single-cycle ops.
  task automatic test_single();
    logic [2:0] ops [7] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic [7:0] as  [7] = '{8'd200, 8'd100, 8'd5, 8'd5, 8'hF0, 8'hC3, 8'h00};
    logic [7:0] bs  [7] = '{8'd100, 8'd100, 8'd7, 8'd7, 8'h0F, 8'h3C, 8'h00};
    logic [2:0] op; logic [7:0] a, b, er; logic ec, ev, edz;
    logic [11:0] obs; int lat; bit busy_ok, pulse_ok;
    for (int i = 0; i < 47; i++) begin
      if (i < 7) begin op = ops[i]; a = as[i]; b = bs[i]; end
      else begin op = 3'($urandom_range(0, 5)); a = 8'($urandom); b = 8'($urandom); end
      modelo(op, a, b, er, ec, ev, edz);
      run_op(op, a, b, -1, obs, lat, busy_ok, pulse_ok);
      checks++;
      if (obs !== {er, er == 8'd0, ec, ev, edz}) begin
        errors++;
        $display("FAIL single_result op=%0d a=%h b=%h got r/z/c/ov/dz=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                 op, a, b, obs[11:4], obs[3], obs[2], obs[1], obs[0], er, er == 8'd0, ec, ev, edz);
      end
      checks++;
      if ({lat, busy_ok, pulse_ok} !== {32'd1, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL single_timing op=%0d got lat=%0d busy_ok=%b pulse_ok=%b want lat=1 1 1",
                 op, lat, busy_ok, pulse_ok);
      end
    end
  endtask

  task automatic test_mul();
    logic [7:0] a, b, er; logic ec, ev, edz;
    logic [11:0] obs; int lat; bit busy_ok, pulse_ok;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin a = 8'd15; b = 8'd17; end
      else if (i == 1) begin a = 8'd16; b = 8'd16; end
      else begin a = 8'($urandom); b = 8'($urandom); end
      modelo(3'd6, a, b, er, ec, ev, edz);
      run_op(3'd6, a, b, -1, obs, lat, busy_ok, pulse_ok);
      checks++;
      if (obs !== {er, er == 8'd0, ec, ev, edz}) begin
        errors++;
        $display("FAIL mul_result a=%h b=%h got r/z/c/ov/dz=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                 a, b, obs[11:4], obs[3], obs[2], obs[1], obs[0], er, er == 8'd0, ec, ev, edz);
      end
      checks++;
      if ({lat, busy_ok, pulse_ok} !== {32'(W + 1), 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL mul_timing got lat=%0d busy_ok=%b pulse_ok=%b want lat=%0d 1 1",
                 lat, busy_ok, pulse_ok, W + 1);
      end
    end
  endtask

  // DIVU with an ignored inicio poked while ITERA is running.
  task automatic test_div();
    logic [7:0] a, b, er; logic ec, ev, edz;
    logic [11:0] obs; int lat, poke; bit busy_ok, pulse_ok;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin a = 8'd200; b = 8'd7; poke = 4; end
      else begin a = 8'($urandom); b = 8'($urandom_range(1, 255)); poke = $urandom_range(1, W); end
      modelo(3'd7, a, b, er, ec, ev, edz);
      run_op(3'd7, a, b, poke, obs, lat, busy_ok, pulse_ok);
      checks++;
      if (obs !== {er, er == 8'd0, ec, ev, edz}) begin
        errors++;
        $display("FAIL div_result a=%h b=%h got r/z/c/ov/dz=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                 a, b, obs[11:4], obs[3], obs[2], obs[1], obs[0], er, er == 8'd0, ec, ev, edz);
      end
      checks++;
      if ({lat, busy_ok, pulse_ok} !== {32'(W + 1), 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL div_timing poke=%0d got lat=%0d busy_ok=%b pulse_ok=%b want lat=%0d 1 1",
                 poke, lat, busy_ok, pulse_ok, W + 1);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [2:0] ops [2] = '{3'd7, 3'd2};
    logic [7:0] as  [2] = '{8'd42, 8'd1};
    logic [7:0] bs  [2] = '{8'd0, 8'd1};
    logic [7:0] er; logic ec, ev, edz;
    logic [11:0] obs; int lat; bit busy_ok, pulse_ok;
    for (int i = 0; i < 2; i++) begin
      modelo(ops[i], as[i], bs[i], er, ec, ev, edz);
      run_op(ops[i], as[i], bs[i], -1, obs, lat, busy_ok, pulse_ok);
      checks++;
      if (obs !== {er, er == 8'd0, ec, ev, edz} || lat != lat_esperada(ops[i], bs[i]) || !busy_ok) begin
        errors++;
        $display("FAIL div_zero_seq step=%0d got r/z/c/ov/dz=%h/%b/%b/%b/%b lat=%0d busy_ok=%b want %h/%b/%b/%b/%b lat=1 1",
                 i, obs[11:4], obs[3], obs[2], obs[1], obs[0], lat, busy_ok, er, er == 8'd0, ec, ev, edz);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op; logic [7:0] a, b, er; logic ec, ev, edz;
    logic [7:0] a2, b2; int lat;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 5)); a = 8'($urandom); b = 8'($urandom);
      u_if.inicio = 1'b1; u_if.sinal_ula = op; u_if.entrada1 = a; u_if.entrada2 = b;
      @(posedge clk); #1;
      modelo(op, a, b, er, ec, ev, edz);
      checks++;
      if ({u_if.valido, u_if.ocupado, u_if.saida_ula, u_if.carry, u_if.overflow} !== {2'b10, er, ec, ev}) begin
        errors++;
        $display("FAIL b2b_single i=%0d got v%b o%b r=%h c%b ov%b want v1 o0 r=%h c%b ov%b",
                 i, u_if.valido, u_if.ocupado, u_if.saida_ula, u_if.carry, u_if.overflow, er, ec, ev);
      end
    end
    a = 8'($urandom); b = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
    u_if.sinal_ula = 3'd6; u_if.entrada1 = a; u_if.entrada2 = b;
    @(posedge clk); #1;
    u_if.inicio = 1'b0;
    lat = 1;
    while (!u_if.valido && lat < 4 * W) begin @(posedge clk); #1; lat++; end
    modelo(3'd6, a, b, er, ec, ev, edz);
    checks++;
    if ({lat, u_if.ocupado, u_if.saida_ula, u_if.carry} !== {32'(W + 1), 1'b0, er, ec}) begin
      errors++;
      $display("FAIL b2b_mul1 got lat=%0d o%b r=%h c%b want lat=%0d o0 r=%h c%b",
               lat, u_if.ocupado, u_if.saida_ula, u_if.carry, W + 1, er, ec);
    end
    u_if.inicio = 1'b1; u_if.sinal_ula = 3'd6; u_if.entrada1 = a2; u_if.entrada2 = b2;
    @(posedge clk); #1;
    u_if.inicio = 1'b0;
    checks++;
    if ({u_if.valido, u_if.ocupado} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_no_gap got v%b o%b want v0 o1", u_if.valido, u_if.ocupado);
    end
    lat = 1;
    while (!u_if.valido && lat < 4 * W) begin @(posedge clk); #1; lat++; end
    modelo(3'd6, a2, b2, er, ec, ev, edz);
    checks++;
    if ({lat, u_if.saida_ula, u_if.carry} !== {32'(W + 1), er, ec}) begin
      errors++;
      $display("FAIL b2b_mul2 got lat=%0d r=%h c%b want lat=%0d r=%h c%b",
               lat, u_if.saida_ula, u_if.carry, W + 1, er, ec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [11:0] obs; int lat; bit busy_ok, pulse_ok; int vistos;
    run_op(3'd0, 8'hFF, 8'h0F, -1, obs, lat, busy_ok, pulse_ok);
    u_if.inicio = 1'b1; u_if.sinal_ula = 3'd6; u_if.entrada1 = 8'hFF; u_if.entrada2 = 8'hFF;
    @(posedge clk); #1;
    u_if.inicio = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({u_if.saida_ula, u_if.valido, u_if.ocupado, u_if.zero, u_if.carry, u_if.overflow, u_if.div_zero}
        !== {8'h00, 6'b001000}) begin
      errors++;
      $display("FAIL abort_reset got r=%h v%b o%b z%b c%b ov%b dz%b want r=00 v0 o0 z1 c0 ov0 dz0",
               u_if.saida_ula, u_if.valido, u_if.ocupado, u_if.zero, u_if.carry, u_if.overflow, u_if.div_zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vistos = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (u_if.valido || u_if.ocupado) vistos++;
    end
    checks++;
    if (vistos != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d cycles with valido/ocupado want 0", vistos);
    end
    run_op(3'd0, 8'hAA, 8'h0F, -1, obs, lat, busy_ok, pulse_ok);
    checks++;
    if ({obs, lat} !== {8'h0A, 4'b0000, 32'd1}) begin
      errors++;
      $display("FAIL abort_and got r/z/c/ov/dz=%h/%b/%b/%b/%b lat=%0d want 0a/0/0/0/0 lat=1",
               obs[11:4], obs[3], obs[2], obs[1], obs[0], lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
